// File: rtl/jtag_dataregbank_pkg.sv
// Shared JTAG definitions: instruction codes, IDCODE value and the user-channel decode helper.
package jtag_pa;

  localparam int IR_W     = 5;
  localparam int MAX_USER = 8;

  localparam logic [31:0] ID_CODE = 32'h4BA0_0477;

  localparam logic [IR_W-1:0] IDCODE = 5'h01;
  localparam logic [IR_W-1:0] BSR    = 5'h02;
  localparam logic [IR_W-1:0] USER0  = 5'h08;
  localparam logic [IR_W-1:0] BYPASS = 5'h1F;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } user_sel_t;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_BSR,
    SEL_USER
  } dr_sel_t;

  // Valid covers the full USER0..USER0+MAX_USER-1 window; the bank narrows it to N_USER.
  function automatic user_sel_t userIdx(input logic [IR_W-1:0] instr);
    user_sel_t       r;
    logic [IR_W-1:0] off;
    off     = instr - USER0;
    r.valid = (instr >= USER0) && (off < IR_W'(MAX_USER));
    r.idx   = off[2:0];
    return r;
  endfunction

endpackage

// File: rtl/jtag_dataregbank_if.sv
// TAP-side bundle: controller state strobes, current instruction and the serial pins.
interface jtag_dataregbank_if;
  import jtag_pa::*;

  // The three state strobes are one-hot and each is high for one TCK per TAP state visit;
  // i_instr is stable for the whole DR scan. There is no back-pressure: the bank acts every cycle.
  logic            i_tdi;
  logic            i_stateIsCaptureDr;
  logic            i_stateIsShiftDr;
  logic            i_stateIsUpdateDr;
  logic [IR_W-1:0] i_instr;
  logic            o_tdo;

  modport master (
    output i_tdi, i_stateIsCaptureDr, i_stateIsShiftDr, i_stateIsUpdateDr, i_instr,
    input  o_tdo
  );

  modport slave (
    input  i_tdi, i_stateIsCaptureDr, i_stateIsShiftDr, i_stateIsUpdateDr, i_instr,
    output o_tdo
  );

endinterface

// File: rtl/jtag_dataregbank_userreg.sv
// One user channel: the update register plus a one-cycle strobe that follows each write.
module jtag_userReg #(
  parameter int               REG_W    = 32,
  parameter logic [REG_W-1:0] USER_RST = '0
) (
  input  logic             i_tclk,
  input  logic             i_trst,
  input  logic             i_we,
  input  logic [REG_W-1:0] i_data,
  output logic [REG_W-1:0] o_data,
  output logic             o_update
);

  always_ff @(posedge i_tclk) begin
    if (i_trst) begin
      o_data   <= USER_RST;
      o_update <= 1'b0;
    end else begin
      o_update <= i_we;
      if (i_we) o_data <= i_data;
    end
  end

endmodule

// File: rtl/jtag_dataregbank.sv
// JTAG data-register bank: owns the DR shift path and drives TDO for IDCODE, BYPASS, BSR and user channels.
module jtag_dataregbank
  import jtag_pa::*;
#(
  parameter int               REG_W    = 32,
  parameter int               N_USER   = 4,
  parameter logic [REG_W-1:0] USER_RST = '0
) (
  input  logic                    i_tclk,
  input  logic                    i_trst,
  jtag_dataregbank_if.slave       tap,
  input  logic [REG_W-1:0]        i_bsr,
  input  logic [N_USER*REG_W-1:0] i_userStatus,
  output logic [N_USER*REG_W-1:0] o_userData,
  output logic [N_USER-1:0]       o_userUpdate
);

  user_sel_t        usel;
  dr_sel_t          sel;
  logic [REG_W-1:0] shift_q;
  logic [REG_W-1:0] status_sel;
  logic             upd_en;

  // Anything not decoded to a real register, including user codes beyond N_USER, is BYPASS.
  always_comb begin
    usel = userIdx(tap.i_instr);
    sel  = SEL_BYPASS;
    if (tap.i_instr == IDCODE)                          sel = SEL_IDCODE;
    else if (tap.i_instr == BSR)                        sel = SEL_BSR;
    else if (usel.valid && (int'(usel.idx) < N_USER))   sel = SEL_USER;
  end

  always_comb begin
    status_sel = '0;
    for (int k = 0; k < N_USER; k++) begin
      if (usel.idx == 3'(k)) status_sel = i_userStatus[k*REG_W +: REG_W];
    end
  end

  always_ff @(posedge i_tclk) begin
    if (i_trst) begin
      shift_q <= '0;
    end else if (tap.i_stateIsCaptureDr) begin
      case (sel)
        SEL_IDCODE: shift_q    <= REG_W'(ID_CODE);
        SEL_BSR:    shift_q    <= i_bsr;
        SEL_USER:   shift_q    <= status_sel;
        default:    shift_q[0] <= 1'b0;
      endcase
    end else if (tap.i_stateIsShiftDr) begin
      // BYPASS is a one-bit path living in bit 0; the upper bits are left untouched.
      if (sel == SEL_BYPASS) shift_q[0] <= tap.i_tdi;
      else                   shift_q    <= {tap.i_tdi, shift_q[REG_W-1:1]};
    end
  end

  assign upd_en = tap.i_stateIsUpdateDr & ~tap.i_stateIsCaptureDr &
                  ~tap.i_stateIsShiftDr & (sel == SEL_USER);

  for (genvar k = 0; k < N_USER; k++) begin : g_user
    jtag_userReg #(
      .REG_W    (REG_W),
      .USER_RST (USER_RST)
    ) u_reg (
      .i_tclk   (i_tclk),
      .i_trst   (i_trst),
      .i_we     (upd_en && (usel.idx == 3'(k))),
      .i_data   (shift_q),
      .o_data   (o_userData[k*REG_W +: REG_W]),
      .o_update (o_userUpdate[k])
    );
  end

  assign tap.o_tdo = tap.i_stateIsShiftDr & ~tap.i_stateIsCaptureDr & shift_q[0];

endmodule

// File: tb/tb_jtag_dataregbank.sv
// Bench for jtag_dataregbank: table of DR scans plus a reset-mid-shift sequence, TDO checked via a scoreboard queue.
module tb_jtag_dataregbank;
  import jtag_pa::*;

  localparam int               REG_W  = 32;
  localparam int               N_USER = 4;
  localparam logic [REG_W-1:0] URST   = 32'hC001_D00D;

  typedef struct {
    logic [IR_W-1:0] instr;
    logic [63:0]     din;
    int              nbits;
    logic            do_upd;
    logic            is_byp;
    logic [31:0]     exp_cap;
    int              exp_chan;
  } vec_t;

  logic                    clk;
  logic                    rst;
  logic [REG_W-1:0]        bsr;
  logic [N_USER*REG_W-1:0] user_status;
  logic [N_USER*REG_W-1:0] user_data;
  logic [N_USER-1:0]       user_update;

  jtag_dataregbank_if tap();

  jtag_dataregbank #(
    .REG_W    (REG_W),
    .N_USER   (N_USER),
    .USER_RST (URST)
  ) dut (
    .i_tclk       (clk),
    .i_trst       (rst),
    .tap          (tap),
    .i_bsr        (bsr),
    .i_userStatus (user_status),
    .o_userData   (user_data),
    .o_userUpdate (user_update)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int          checks = 0;
  int          errors = 0;
  logic [0:0]  exp_q[$];
  logic [31:0] user_exp[N_USER];
  logic [31:0] status_c[N_USER];
  vec_t        vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_data();
    for (int k = 0; k < N_USER; k++)
      chk($sformatf("user_data%0d", k), 64'(user_data[k*REG_W +: REG_W]), 64'(user_exp[k]));
  endtask

  // scoreboard: one expected TDO bit per Shift-DR cycle
  always @(negedge clk) begin
    logic [0:0] e;
    #2;
    if (tap.i_stateIsShiftDr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tdo_sb actual=%b expected=<none queued>", tap.o_tdo);
      end else begin
        e = exp_q.pop_front();
        chk("tdo", 64'(tap.o_tdo), 64'(e));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst)
      assert ($onehot0({tap.i_stateIsCaptureDr, tap.i_stateIsShiftDr, tap.i_stateIsUpdateDr}))
        else $error("TAP state strobes overlap");
  end

  task automatic idle_drive();
    tap.i_stateIsCaptureDr = 1'b0;
    tap.i_stateIsShiftDr   = 1'b0;
    tap.i_stateIsUpdateDr  = 1'b0;
    tap.i_tdi              = 1'b0;
  endtask

  // driver: one full capture / shift / optional update scan
  task automatic run_vec(input vec_t v);
    logic [95:0]       stream;
    logic [95:0]       tmp;
    logic [31:0]       fin;
    logic [N_USER-1:0] mask;
    stream = v.is_byp ? {31'b0, v.din, 1'b0} : {v.din, v.exp_cap};
    tmp    = {v.din, v.exp_cap} >> v.nbits;
    fin    = tmp[31:0];
    mask   = '0;
    @(negedge clk);
    tap.i_instr            = v.instr;
    tap.i_stateIsCaptureDr = 1'b1;
    for (int i = 0; i < v.nbits; i++) begin
      @(negedge clk);
      tap.i_stateIsCaptureDr = 1'b0;
      tap.i_stateIsShiftDr   = 1'b1;
      tap.i_tdi              = v.din[i];
      exp_q.push_back(stream[i]);
    end
    @(negedge clk);
    tap.i_stateIsShiftDr  = 1'b0;
    tap.i_tdi             = 1'b0;
    tap.i_stateIsUpdateDr = v.do_upd;
    @(negedge clk);
    tap.i_stateIsUpdateDr = 1'b0;
    #1;
    if (v.do_upd && v.exp_chan >= 0) begin
      user_exp[v.exp_chan] = fin;
      mask[v.exp_chan]     = 1'b1;
    end
    chk("strobe", 64'(user_update), 64'(mask));
    chk_data();
    @(negedge clk);
    #1;
    chk("strobe_clear", 64'(user_update), 64'd0);
  endtask

  initial begin
    logic [31:0] rnd;
    status_c[0] = 32'h0BAD_F00D;
    status_c[1] = 32'h1111_2222;
    status_c[2] = 32'hA5A5_0F0F;
    status_c[3] = 32'h3333_CCCC;
    for (int k = 0; k < N_USER; k++) begin
      user_status[k*REG_W +: REG_W] = status_c[k];
      user_exp[k] = URST;
    end
    bsr = 32'hDEAD_BEEF;
    rnd = $urandom();

    vecs[0] = '{IDCODE,         64'h0,                   40, 1'b1, 1'b0, ID_CODE,       -1};
    vecs[1] = '{BYPASS,         64'hD,                    5, 1'b1, 1'b1, 32'h0,         -1};
    vecs[2] = '{USER0 + 5'd2,   64'h1234_5678,           32, 1'b1, 1'b0, 32'hA5A5_0F0F,  2};
    vecs[3] = '{USER0 + 5'd4,   64'h6,                    4, 1'b1, 1'b1, 32'h0,         -1};
    vecs[4] = '{BSR,            64'h0,                   32, 1'b1, 1'b0, 32'hDEAD_BEEF, -1};
    vecs[5] = '{USER0,          64'hC3,                   8, 1'b1, 1'b0, 32'h0BAD_F00D,  0};
    vecs[6] = '{USER0 + 5'd3,   64'h0000_00FE_DCBA_9876, 40, 1'b1, 1'b0, 32'h3333_CCCC,  3};
    vecs[7] = '{USER0 + 5'd2,   64'h8765_4321,           32, 1'b1, 1'b0, 32'hA5A5_0F0F,  2};
    vecs[8] = '{USER0 + 5'd1,   {32'h0, rnd},            32, 1'b1, 1'b0, 32'h1111_2222,  1};
    vecs[9] = '{IDCODE,         64'(~rnd),               32, 1'b0, 1'b0, ID_CODE,       -1};

    idle_drive();
    tap.i_instr = BYPASS;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_tdo", 64'(tap.o_tdo), 64'd0);
    chk("reset_strobe", 64'(user_update), 64'd0);
    chk_data();

    for (int v = 0; v < 10; v++) run_vec(vecs[v]);

    // reset after ten shift bits into USER1
    @(negedge clk);
    tap.i_instr            = USER0 + 5'd1;
    tap.i_stateIsCaptureDr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tap.i_stateIsCaptureDr = 1'b0;
      tap.i_stateIsShiftDr   = 1'b1;
      tap.i_tdi              = 1'($urandom_range(0, 1));
      exp_q.push_back(status_c[1][i]);
    end
    @(negedge clk);
    tap.i_stateIsShiftDr = 1'b0;
    rst                  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N_USER; k++) user_exp[k] = URST;
    #1;
    chk("midrst_tdo", 64'(tap.o_tdo), 64'd0);
    chk("midrst_strobe", 64'(user_update), 64'd0);
    chk_data();
    @(negedge clk);
    tap.i_stateIsUpdateDr = 1'b0;
    #1;
    chk("midrst_strobe2", 64'(user_update), 64'd0);
    // shift register must be cleared: first bit out without a capture is 0
    @(negedge clk);
    tap.i_stateIsShiftDr = 1'b1;
    tap.i_tdi            = 1'b1;
    exp_q.push_back(1'b0);
    @(negedge clk);
    idle_drive();
    run_vec('{USER0 + 5'd1, 64'h0F1E_2D3C, 32, 1'b1, 1'b0, 32'h1111_2222, 1});

    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_dataregbank.md
# jtag_dataRegBank

Parametrised JTAG data-register bank. It owns the DR shift path (capture, shift, update), so it needs no external shift register, and it drives TDO directly. It holds IDCODE, BYPASS, BSR and `N_USER` independent user channels. Each user channel has its own update register, a captured status input and a one-cycle update strobe to external logic. The bank sits between the TAP controller / instruction register and the user-facing logic.

## Interface
Parameters:
- `REG_W`, 32: width of the IDCODE, BSR and user registers and of the shift register.
- `N_USER`, 4: number of user channels, 1..8.
- `USER_RST`, '0: reset value of every user register (`REG_W` bits).

Ports:
- `i_tclk`  in  1: TCK. Single clock domain.
- `i_trst`  in  1: reset. Synchronous, active-high.
- `i_tdi`  in  1: serial data in.
- `i_stateIsCaptureDr`  in  1: TAP is in Capture-DR.
- `i_stateIsShiftDr`  in  1: TAP is in Shift-DR.
- `i_stateIsUpdateDr`  in  1: TAP is in Update-DR.
- `i_instr`  in  `IR_W`: current instruction. Stable outside Update-IR.
- `i_bsr`  in  `REG_W`: boundary-scan sample.
- `i_userStatus`  in  `N_USER*REG_W`: per-channel status. Channel k occupies bits [k*REG_W +: REG_W].
- `o_tdo`  out  1: serial data out.
- `o_userData`  out  `N_USER*REG_W`: per-channel user registers.
- `o_userUpdate`  out  `N_USER`: one-cycle strobe per channel indicating new data.

## Operation
Instruction decode:
- `IDCODE`, `BYPASS` and `BSR` use the existing codes.
- `USER0 + k`, for k < `N_USER`, selects user channel k.
- Any other code behaves as BYPASS.

Capture-DR: `shift_q` is loaded as follows.
- IDCODE: `ID_CODE`.
- BSR: `i_bsr`.
- USERk: `i_userStatus[k]`.
- BYPASS / unknown: `shift_q[0]` ← 0; other bits are unchanged.

Shift-DR: LSB first.
- REG_W-length selection: `shift_q` ← {`i_tdi`, `shift_q[REG_W-1:1]`}.
- BYPASS / unknown: `shift_q[0]` ← `i_tdi`; other bits are unchanged (1-bit path).

TDO:
- `o_tdo` = `shift_q[0]`, combinational from the register.
- `o_tdo` = 0 when not in Shift-DR.

Update-DR:
- USERk: `user_q[k]` ← `shift_q`.
- IDCODE, BYPASS and BSR: no register is written (IDCODE is read-only; this block has no BSR update stage).

Update strobe:
- `o_userUpdate[k]` is registered and is high for exactly one cycle, the cycle after the Update-DR cycle that wrote channel k.
- At most one bit of `o_userUpdate` is high at a time.

Strobe priority: the three state inputs are one-hot by contract. If more than one is asserted, the priority is `i_trst` > capture > shift > update. The bench flags any overlap with an assertion.

Hold: with no strobe asserted, all registers hold.

## Timing
Reset values (next edge with `i_trst` = 1): `shift_q` = 0; every `user_q` = `USER_RST`; `o_userUpdate` = 0; `o_tdo` = 0.

Reset mid-shift:
- Aborts the shift.
- Any user register already updated keeps `USER_RST`.
- No strobe is emitted.

Capture latency: the captured value's bit 0 is on `o_tdo` in the first Shift-DR cycle.

TDI-to-TDO latency:
- `REG_W` Shift-DR cycles for REG_W registers.
- 1 cycle for BYPASS.

Update latency:
- `o_userData` changes one edge after the Update-DR cycle.
- `o_userUpdate` is high during the cycle that follows that edge.

Back-to-back updates: consecutive updates to the same channel, separated by a full capture/shift sequence, each produce a separate strobe.

Channel independence: channels not addressed retain their value.

Short or long shifts:
- Shifting fewer than `REG_W` bits updates with the partially shifted value.
- Shifting more than `REG_W` bits leaves the last `REG_W` bits shifted in.
- No error is reported in either case.

## Structure
The package `jtag_pa` gains:
- `IR_W`.
- `ID_CODE`.
- The existing `IDCODE`, `BYPASS` and `BSR` instruction codes.
- `USER0`.
- `MAX_USER` = 8.
- Function `userIdx(instr)`, returning the channel index plus a valid flag.

Sub-module `jtag_userReg`:
- Instantiated once per channel with a generate loop.
- Contains the `REG_W` update register and the registered strobe.
- Inputs: clock, reset, write-enable and data.

Everything else (the shift register, capture mux and TDO) lives in the top module.

## Test plan
- Reset, then IDCODE: capture then 32 shifts with `i_tdi` = 0. `o_tdo` serialises `ID_CODE` LSB first; after that, 0s emerge.
- BYPASS: shift pattern 1,0,1,1. `o_tdo` reproduces the pattern delayed by 1 cycle; bit 0 emerges 0 first.
- USER2 with `N_USER` = 4, `i_userStatus[2]` = 0xA5A5_0F0F: capture/shift-in 0x1234_5678/update.
  - `o_tdo` streams 0xA5A5_0F0F.
  - `o_userData[2]` = 0x1234_5678.
  - `o_userUpdate` = 4'b0100 for one cycle.
  - Other channels stay `USER_RST`.
- Unknown code (for example `USER0 + N_USER`): behaves as BYPASS, and update writes nothing and pulses no strobe.
- `i_trst` asserted after 10 shift bits into USER1: all registers return to their reset values, `o_userUpdate` stays 0, and a subsequent full USER1 transaction works.
- BSR with `i_bsr` = 0xDEAD_BEEF: `o_tdo` streams 0xDEAD_BEEF, and update leaves `o_userData` unchanged.
